// File: rtl/acorn_phase_ctrl.sv
// Step sequencer for the ACORN-128 core: walks INIT -> AD -> ENC -> FINAL one
// state-update step per accepted cycle and decodes the per-step control bits.
module acorn_phase_ctrl #(
  parameter int INIT_STEPS  = 1792,
  parameter int AD_BITS     = 128,
  parameter int PT_BITS     = 128,
  parameter int PAD_STEPS   = 256,
  parameter int FINAL_STEPS = 768,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             step_rdy,
  output logic             busy,
  output logic             step_en,
  output logic             ca,
  output logic             cb,
  output logic [2:0]       mbit_sel,
  output logic [6:0]       bit_idx,
  output logic             key_flip,
  output logic             ks_valid,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] step_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_AD    = 3'd2,
    PH_ENC   = 3'd3,
    PH_FINAL = 3'd4,
    PH_DONE  = 3'd5
  } phase_e;

  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_KEY  = 3'd1;
  localparam logic [2:0] SEL_IV   = 3'd2;
  localparam logic [2:0] SEL_AD   = 3'd3;
  localparam logic [2:0] SEL_PT   = 3'd4;
  localparam logic [2:0] SEL_ONE  = 3'd5;

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_STEPS - 1);
  localparam logic [CNT_W-1:0] AD_LAST    = CNT_W'(AD_BITS + PAD_STEPS - 1);
  localparam logic [CNT_W-1:0] ENC_LAST   = CNT_W'(PT_BITS + PAD_STEPS - 1);
  localparam logic [CNT_W-1:0] FINAL_LAST = CNT_W'(FINAL_STEPS - 1);

  localparam logic [CNT_W-1:0] KEY_END    = CNT_W'(128);
  localparam logic [CNT_W-1:0] IV_END     = CNT_W'(256);
  localparam logic [CNT_W-1:0] AD_END     = CNT_W'(AD_BITS);
  localparam logic [CNT_W-1:0] AD_CA_END  = CNT_W'(AD_BITS + 128);
  localparam logic [CNT_W-1:0] PT_END     = CNT_W'(PT_BITS);
  localparam logic [CNT_W-1:0] PT_CA_END  = CNT_W'(PT_BITS + 128);

  phase_e           state_reg, state_next;
  phase_e           phase_after;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] phase_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= PH_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    phase_after = PH_IDLE;
    phase_last  = '0;
    busy        = 1'b0;
    step_en     = 1'b0;
    ca          = 1'b0;
    cb          = 1'b0;
    mbit_sel    = SEL_ZERO;
    bit_idx     = 7'd0;
    key_flip    = 1'b0;
    ks_valid    = 1'b0;
    done        = 1'b0;

    case (state_reg)
      PH_IDLE: begin
        // abort outranks start even when nothing is running
        if (start && !abort) begin
          state_next = PH_INIT;
          cnt_next   = '0;
        end
      end

      PH_INIT: begin
        busy        = 1'b1;
        ca          = 1'b1;
        cb          = 1'b1;
        phase_last  = INIT_LAST;
        phase_after = PH_AD;
        mbit_sel    = ((cnt_reg >= KEY_END) && (cnt_reg < IV_END)) ? SEL_IV : SEL_KEY;
        bit_idx     = cnt_reg[6:0];
        key_flip    = (cnt_reg == IV_END);
      end

      PH_AD: begin
        busy        = 1'b1;
        cb          = 1'b1;
        ca          = (cnt_reg < AD_CA_END);
        phase_last  = AD_LAST;
        phase_after = PH_ENC;
        if (cnt_reg < AD_END) begin
          mbit_sel = SEL_AD;
          bit_idx  = cnt_reg[6:0];
        end else if (cnt_reg == AD_END) begin
          mbit_sel = SEL_ONE;
        end
      end

      PH_ENC: begin
        busy        = 1'b1;
        ca          = (cnt_reg < PT_CA_END);
        ks_valid    = (cnt_reg < PT_END);
        phase_last  = ENC_LAST;
        phase_after = PH_FINAL;
        if (cnt_reg < PT_END) begin
          mbit_sel = SEL_PT;
          bit_idx  = cnt_reg[6:0];
        end else if (cnt_reg == PT_END) begin
          mbit_sel = SEL_ONE;
        end
      end

      PH_FINAL: begin
        busy        = 1'b1;
        ca          = 1'b1;
        cb          = 1'b1;
        phase_last  = FINAL_LAST;
        phase_after = PH_DONE;
      end

      PH_DONE: begin
        done       = 1'b1;
        state_next = PH_IDLE;
        cnt_next   = '0;
      end

      default: begin
        state_next = PH_IDLE;
        cnt_next   = '0;
      end
    endcase

    step_en = busy & step_rdy;

    // abort wins over the last-step phase advance
    if (busy) begin
      if (abort) begin
        state_next = PH_IDLE;
        cnt_next   = '0;
      end else if (step_en) begin
        if (cnt_reg == phase_last) begin
          state_next = phase_after;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

  assign phase    = state_reg;
  assign step_cnt = cnt_reg;

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// Directed bench for acorn_phase_ctrl: decode table, full runs, stalls, reset and abort.
module tb_acorn_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, step_rdy;
  logic        busy, step_en, ca, cb, key_flip, ks_valid, done;
  logic [2:0]  mbit_sel, phase;
  logic [6:0]  bit_idx;
  logic [10:0] step_cnt;

  acorn_phase_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_rdy(step_rdy),
    .busy(busy), .step_en(step_en), .ca(ca), .cb(cb), .mbit_sel(mbit_sel),
    .bit_idx(bit_idx), .key_flip(key_flip), .ks_valid(ks_valid), .phase(phase),
    .step_cnt(step_cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int st;
    bit ca;
    bit cb;
    int sel;
    int idx;
    bit flip;
    bit ks;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  bit   hit[NV];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_ph = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (ph=%0d step=%0d)", name, act, exp, exp_ph, exp_cnt);
    end
  endtask

  function automatic int plen(input int p);
    case (p)
      1: return 1792;
      2: return 384;
      3: return 384;
      4: return 768;
      default: return 1;
    endcase
  endfunction

  // Reference phase/step model, advanced once per clock edge.
  task automatic model_step();
    case (exp_ph)
      0: if (start && !abort) begin exp_ph = 1; exp_cnt = 0; end
      5: begin exp_ph = 0; exp_cnt = 0; end
      default: begin
        if (abort) begin
          exp_ph = 0; exp_cnt = 0;
        end else if (step_rdy) begin
          if (exp_cnt == plen(exp_ph) - 1) begin exp_ph = exp_ph + 1; exp_cnt = 0; end
          else exp_cnt = exp_cnt + 1;
        end
      end
    endcase
  endtask

  task automatic check_cycle();
    bit act_exp;
    act_exp = (exp_ph >= 1 && exp_ph <= 4);
    chk("phase", phase, exp_ph);
    chk("step_cnt", step_cnt, exp_cnt);
    chk("busy", busy, act_exp);
    chk("step_en", step_en, act_exp & step_rdy);
    chk("done", done, exp_ph == 5);
    if (!act_exp) begin
      chk("idle_ca", ca, 0);
      chk("idle_cb", cb, 0);
      chk("idle_sel", mbit_sel, 0);
      chk("idle_flip", key_flip, 0);
      chk("idle_ks", ks_valid, 0);
    end
    for (int k = 0; k < NV; k++) begin
      if (vecs[k].ph == exp_ph && vecs[k].st == exp_cnt) begin
        hit[k] = 1'b1;
        chk("vec_ca", ca, vecs[k].ca);
        chk("vec_cb", cb, vecs[k].cb);
        chk("vec_sel", mbit_sel, vecs[k].sel);
        chk("vec_idx", bit_idx, vecs[k].idx);
        chk("vec_flip", key_flip, vecs[k].flip);
        chk("vec_ks", ks_valid, vecs[k].ks);
      end
    end
  endtask

  // One operation from IDLE back to IDLE; start is held for 3 cycles so the
  // two extra cycles land in INIT and must be ignored.
  task automatic run_op(input bit rnd, input int ab_ph, input int ab_st, input bit full);
    int cycles, en_cnt, done_cnt;
    int seq[$];
    int exp_seq[$];
    logic [2:0] last_ph;
    cycles = 0; en_cnt = 0; done_cnt = 0;
    last_ph = phase;
    do begin
      @(negedge clk);
      start    = (cycles < 3);
      step_rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      abort    = (exp_ph == ab_ph && exp_cnt == ab_st);
      #1;
      check_cycle();
      if (step_en === 1'b1 && done_cnt == 0) en_cnt++;
      if (done === 1'b1) done_cnt++;
      if (phase !== last_ph) begin seq.push_back(int'(phase)); last_ph = phase; end
      model_step();
      cycles++;
    end while (exp_ph != 0 && cycles < 20000);
    chk("cycle_budget", cycles < 20000, 1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; step_rdy = 1'b1;
    #1;
    check_cycle();
    if (phase !== last_ph) seq.push_back(int'(phase));
    if (full) begin
      exp_seq = '{1, 2, 3, 4, 5, 0};
      chk("step_en_to_done", en_cnt, 3328);
      chk("done_pulses", done_cnt, 1);
    end else begin
      exp_seq = '{1, 2, 3, 4, 0};
      chk("done_pulses_abort", done_cnt, 0);
    end
    chk("phase_seq_len", seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++)
      chk("phase_seq", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
  endtask

  initial begin
    //            ph  st    ca cb sel idx flip ks
    vecs[0]  = '{1, 0,    1, 1, 1, 0,   0, 0};
    vecs[1]  = '{1, 127,  1, 1, 1, 127, 0, 0};
    vecs[2]  = '{1, 128,  1, 1, 2, 0,   0, 0};
    vecs[3]  = '{1, 255,  1, 1, 2, 127, 0, 0};
    vecs[4]  = '{1, 256,  1, 1, 1, 0,   1, 0};
    vecs[5]  = '{1, 257,  1, 1, 1, 1,   0, 0};
    vecs[6]  = '{1, 1791, 1, 1, 1, 127, 0, 0};
    vecs[7]  = '{2, 0,    1, 1, 3, 0,   0, 0};
    vecs[8]  = '{2, 127,  1, 1, 3, 127, 0, 0};
    vecs[9]  = '{2, 128,  1, 1, 5, 0,   0, 0};
    vecs[10] = '{2, 129,  1, 1, 0, 0,   0, 0};
    vecs[11] = '{2, 255,  1, 1, 0, 0,   0, 0};
    vecs[12] = '{2, 256,  0, 1, 0, 0,   0, 0};
    vecs[13] = '{2, 383,  0, 1, 0, 0,   0, 0};
    vecs[14] = '{3, 0,    1, 0, 4, 0,   0, 1};
    vecs[15] = '{3, 127,  1, 0, 4, 127, 0, 1};
    vecs[16] = '{3, 128,  1, 0, 5, 0,   0, 0};
    vecs[17] = '{3, 255,  1, 0, 0, 0,   0, 0};
    vecs[18] = '{3, 256,  0, 0, 0, 0,   0, 0};
    vecs[19] = '{4, 0,    1, 1, 0, 0,   0, 0};
    vecs[20] = '{4, 767,  1, 1, 0, 0,   0, 0};
    for (int k = 0; k < NV; k++) hit[k] = 1'b0;

    rst = 1'b0; start = 1'b0; abort = 1'b0; step_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_en", step_en, 0);
    chk("rst_ca", ca, 0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of INIT
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (500) @(negedge clk);
    #1;
    chk("pre_rst_phase", phase, 1);
    chk("pre_rst_step", step_cnt, 500);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_step", step_cnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_step_en", step_en, 0);
    chk("async_rst_sel", mbit_sel, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_ph = 0; exp_cnt = 0;

    // Full run without stalls, then with random stalls
    run_op(1'b0, -1, -1, 1'b1);
    for (int k = 0; k < NV; k++) chk("vector_reached", hit[k], 1);
    run_op(1'b1, -1, -1, 1'b1);

    // Abort at FINAL step 10
    run_op(1'b0, 4, 10, 1'b0);

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_idle_phase", phase, 0);
    chk("start_abort_idle_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("idle_hold_phase", phase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
